// File: rtl/led_flip_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : led_flip_ctrl
//  Purpose  : Runtime-configurable LED pattern sequencer. A programmable
//             divisor produces a single-cycle tick enable on i_clk, and each
//             tick advances the LED pattern (ALL_OFF / BLINK / SHIFT /
//             BOUNCE). Mode and divisor arrive through a valid/ready
//             handshake. While running, a new setting is held pending and
//             applied on the next tick, so a period is never cut short.
//  Ports    : i_clk, i_rst        clock, synchronous active-high reset
//             i_cfg_valid/o_cfg_ready, i_cfg_mode, i_cfg_div  config handshake
//             i_start, i_stop     level-sampled run control (stop wins)
//             o_led, o_tick, o_busy  registered pattern, tick pulse, RUN flag
//  Revision : 1.0  initial release
// ============================================================================
module led_flip_ctrl #(
  parameter int P_LED_NUM      = 4,
  parameter int P_DIV_W        = 16,
  parameter int P_DIV_DEFAULT  = 50000,
  parameter int P_MODE_DEFAULT = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_cfg_valid,
  output logic                 o_cfg_ready,
  input  logic [1:0]           i_cfg_mode,
  input  logic [P_DIV_W-1:0]   i_cfg_div,
  input  logic                 i_start,
  input  logic                 i_stop,
  output logic [P_LED_NUM-1:0] o_led,
  output logic                 o_tick,
  output logic                 o_busy
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [1:0] c_MODE_ALL_OFF = 2'd0;
  localparam logic [1:0] c_MODE_BLINK   = 2'd1;
  localparam logic [1:0] c_MODE_SHIFT   = 2'd2;
  localparam logic [1:0] c_MODE_BOUNCE  = 2'd3;
  localparam logic       c_DIR_UP       = 1'b0;
  localparam logic       c_DIR_DOWN     = 1'b1;

  state_t               r_state;
  logic [1:0]           r_mode;
  logic [P_DIV_W-1:0]   r_div;
  logic                 r_pend;
  logic [1:0]           r_pmode;
  logic [P_DIV_W-1:0]   r_pdiv;
  logic                 r_dir;
  logic [P_DIV_W-1:0]   r_cnt;
  logic [P_LED_NUM-1:0] r_led;
  logic                 r_tick;
  logic                 r_cfg_ready;

  logic [P_DIV_W-1:0]   w_eff_m1;
  logic                 w_tick_cond;
  logic                 w_cfg_acc;
  logic [P_LED_NUM-1:0] w_led_adv;
  logic                 w_dir_adv;
  logic [P_LED_NUM-1:0] w_shl;
  logic [P_LED_NUM-1:0] w_shr;

  // Initial pattern shown when a mode is (re)started.
  function automatic logic [P_LED_NUM-1:0] f_init(input logic [1:0] mode);
    logic [P_LED_NUM-1:0] v;
    v = '0;
    case (mode)
      c_MODE_BLINK:                v = '1;
      c_MODE_SHIFT, c_MODE_BOUNCE: v[0] = 1'b1;
      default:                     v = '0;
    endcase
    return v;
  endfunction

  // A divisor of 0 behaves as 1, so the terminal count is 0 in both cases.
  // Comparing cnt against div-1 keeps everything in P_DIV_W bits, which lets
  // the all-ones divisor work without a wider counter.
  assign w_eff_m1    = (r_div == '0) ? '0 : r_div - P_DIV_W'(1);
  assign w_tick_cond = (r_state == S_RUN) && (r_cnt == w_eff_m1);
  assign w_cfg_acc   = i_cfg_valid & r_cfg_ready;

  assign w_shl = r_led << 1;
  assign w_shr = r_led >> 1;

  always_comb begin
    w_led_adv = r_led;
    w_dir_adv = r_dir;
    case (r_mode)
      c_MODE_ALL_OFF: w_led_adv = '0;
      c_MODE_BLINK:   w_led_adv = ~r_led;
      c_MODE_SHIFT: begin
        // Rotate left; with a single LED this degenerates to a hold.
        for (int i = 0; i < P_LED_NUM; i++) begin
          w_led_adv[i] = r_led[(i + P_LED_NUM - 1) % P_LED_NUM];
        end
      end
      default: begin
        // Direction flips on arrival at an end bit, so each end bit is
        // displayed for exactly one tick before the walk reverses.
        if (P_LED_NUM > 1) begin
          if (r_dir == c_DIR_UP) begin
            w_led_adv = w_shl;
            if (w_shl[P_LED_NUM-1]) w_dir_adv = c_DIR_DOWN;
          end else begin
            w_led_adv = w_shr;
            if (w_shr[0]) w_dir_adv = c_DIR_UP;
          end
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_mode      <= 2'(P_MODE_DEFAULT);
      r_div       <= P_DIV_W'(P_DIV_DEFAULT);
      r_pend      <= 1'b0;
      r_pmode     <= 2'(P_MODE_DEFAULT);
      r_pdiv      <= P_DIV_W'(P_DIV_DEFAULT);
      r_dir       <= c_DIR_UP;
      r_cnt       <= '0;
      r_led       <= '0;
      r_tick      <= 1'b0;
      r_cfg_ready <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tick      <= 1'b0;
          r_cnt       <= '0;
          r_dir       <= c_DIR_UP;
          r_cfg_ready <= 1'b1;
          if (w_cfg_acc) begin
            r_mode <= i_cfg_mode;
            r_div  <= i_cfg_div;
          end
          if (i_start && !i_stop) begin
            r_state <= S_RUN;
            // A setting accepted on the same edge is the one that starts.
            r_led   <= f_init(w_cfg_acc ? i_cfg_mode : r_mode);
          end
        end

        default: begin
          if (i_stop) begin
            // Stop suppresses any tick due at this edge and flushes config.
            r_state     <= S_IDLE;
            r_led       <= '0;
            r_cnt       <= '0;
            r_dir       <= c_DIR_UP;
            r_tick      <= 1'b0;
            r_pend      <= 1'b0;
            r_cfg_ready <= 1'b1;
            if (r_pend) begin
              r_mode <= r_pmode;
              r_div  <= r_pdiv;
            end else if (w_cfg_acc) begin
              r_mode <= i_cfg_mode;
              r_div  <= i_cfg_div;
            end
          end else begin
            if (w_tick_cond) begin
              r_cnt  <= '0;
              r_tick <= 1'b1;
              if (r_pend) begin
                r_mode      <= r_pmode;
                r_div       <= r_pdiv;
                r_led       <= f_init(r_pmode);
                r_dir       <= c_DIR_UP;
                r_pend      <= 1'b0;
                r_cfg_ready <= 1'b1;
              end else begin
                r_led <= w_led_adv;
                r_dir <= w_dir_adv;
              end
            end else begin
              r_cnt  <= r_cnt + P_DIV_W'(1);
              r_tick <= 1'b0;
            end
            // Acceptance is only possible with nothing pending, so an offer
            // landing on a tick edge never disturbs the tick itself and
            // simply waits for the following one.
            if (w_cfg_acc) begin
              r_pmode     <= i_cfg_mode;
              r_pdiv      <= i_cfg_div;
              r_pend      <= 1'b1;
              r_cfg_ready <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  assign o_led       = r_led;
  assign o_tick      = r_tick;
  assign o_busy      = (r_state == S_RUN);
  assign o_cfg_ready = r_cfg_ready;

endmodule
`default_nettype wire

// File: doc/led_flip_ctrl.md
# led_flip_ctrl

Runtime-configurable LED pattern sequencer for the LED flip design. It generates its own single-cycle tick enable from a programmable divisor instead of a divided clock, so everything runs on `i_clk`. It advances an LED pattern on every tick, and accepts new mode/divisor settings through a valid/ready handshake. While running, a new setting is scheduled and applied only at a tick boundary, so a period is never cut short.

## Interface
- `P_LED_NUM`, 4: number of LEDs, ≥1
- `P_DIV_W`, 16: divisor/counter width
- `P_DIV_DEFAULT`, 50000: divisor after reset
- `P_MODE_DEFAULT`, 2: mode after reset

- `i_clk`  in  1  system clock; single clock domain
- `i_rst`  in  1  synchronous, active-high reset
- `i_cfg_valid`  in  1  config offer
- `o_cfg_ready`  out  1  config can be accepted; transfer happens when valid&ready at a rising edge
- `i_cfg_mode`  in  2  0 ALL_OFF, 1 BLINK, 2 SHIFT, 3 BOUNCE
- `i_cfg_div`  in  P_DIV_W  tick period in cycles; 0 is treated as 1
- `i_start`  in  1  level-sampled start request
- `i_stop`  in  1  level-sampled stop request
- `o_led`  out  P_LED_NUM  registered LED pattern
- `o_tick`  out  1  registered one-cycle pulse, high in the first cycle a new pattern is visible
- `o_busy`  out  1  high in state RUN

## Operation
- **Reset values:** state IDLE, `o_led`=0, `o_tick`=0, `o_busy`=0, `o_cfg_ready`=1, mode=`P_MODE_DEFAULT`, div=`P_DIV_DEFAULT`, pending=0, bounce dir=up, counter=0.
- **FSM, two states:**
  - IDLE → RUN on `i_start`.
  - RUN → IDLE on `i_stop`.
  - `i_start` and `i_stop` high together: stop wins, so IDLE stays IDLE.
  - `i_start` in RUN and `i_stop` in IDLE are ignored.
- **Initial pattern per mode:**
  - ALL_OFF: 0
  - BLINK: all ones
  - SHIFT: one-hot bit0
  - BOUNCE: one-hot bit0, dir=up
- **Divisor and counter:**
  - Effective divisor eff = max(div,1).
  - Counter cnt runs 0..eff-1 in RUN only. It is held at 0 in IDLE.
  - Tick condition: RUN and cnt==eff-1. At that edge cnt returns to 0.
- **On tick (no pending config), pattern advance:**
  - ALL_OFF: stays 0.
  - BLINK: `o_led` is inverted.
  - SHIFT: rotate left, MSB wraps to bit0.
  - BOUNCE: one-hot moves toward MSB while dir=up. Reaching bit `P_LED_NUM`-1 sets dir=down. Reaching bit0 sets dir=up. The end bit is shown for exactly one tick.
  - `P_LED_NUM`=1: SHIFT and BOUNCE hold at 1.
- **Config in IDLE:** accepted whenever offered. Mode/div are loaded at that edge and `o_cfg_ready` stays 1.
- **Config in RUN, while pending=0:**
  - Accepted; the values are stored and pending=1.
  - `o_cfg_ready` is 0 while pending=1.
  - At the next tick: mode/div are loaded, `o_led` gets the new mode's initial pattern instead of advancing, pending clears, and `o_cfg_ready` returns to 1 in the cycle after the tick edge.
  - The accepting cycle may coincide with the tick condition. In that case the current tick uses the old config and the new config waits for the following tick.
- **Start:** cnt=0 and `o_led` gets the current mode's initial pattern.
- **Stop:** `o_led`=0, cnt=0, dir=up. Any pending config is applied immediately and pending clears, so `o_cfg_ready` is 1 the next cycle.
- **Reset while running:** reset has priority over all other inputs and forces the reset values at the next edge. Asserting `i_rst` between edges has no effect.

## Timing
- Start sampled at edge E0 → `o_busy`=1 and initial pattern from E0+1 cycle. First pattern change at edge E0+eff. From then on, changes occur every eff cycles exactly.
- `o_tick` is high for exactly 1 cycle per period, aligned with the new `o_led` value. It is never high in IDLE.
- eff=1: `o_tick` stays high continuously and the pattern advances every cycle.
- Stop sampled at edge E → `o_led`=0 and `o_busy`=0 from E. No tick is generated at E even if the tick condition holds.
- Counter wrap: div=2^`P_DIV_W`-1 must work without overflow. The comparison uses `P_DIV_W` bits.

## Test plan
- Reset: hold `i_rst` 2 cycles with random inputs → `o_led`=0000, `o_tick`=0, `o_busy`=0, `o_cfg_ready`=1. A reset pulse between edges has no effect.
- IDLE cfg mode=2 div=3, then start → `o_led`=0001, then 0010, 0100, 1000, 0001. Each change is exactly 3 cycles apart, with `o_tick` one cycle high per change.
- cfg mode=3 div=1, start → 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010 on consecutive cycles and `o_tick` stays at 1. Repeat with div=0 and require an identical result.
- Running mode=2 div=4, offer mode=1 div=2 at cnt=1 → `o_cfg_ready` goes 0. Pattern keeps shifting until the next tick, then `o_led`=1111, then 0000, 1111 every 2 cycles. `o_cfg_ready` is 1 again after the tick. Repeat with the offer landing exactly on the tick cycle and require the switch to occur one old period later.
- Start and stop together in IDLE → stays IDLE. In RUN with a config pending, assert stop → `o_led`=0000 and `o_busy`=0 next cycle, the new mode is loaded, and `o_cfg_ready`=1.
- Mode=1 div=5, assert `i_rst` mid-period → all reset values at that edge. After a subsequent start, `o_led` shows mode `P_MODE_DEFAULT` with period 50000.
